// File: rtl/tt_um_jimktrains_vslc_pkg.sv
// Shared VSLC definitions: default data width and the capture FSM state encoding.
package tt_um_jimktrains_vslc_pkg;

  localparam int VSLC_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } capture_state_t;

endpackage

// File: rtl/tt_um_jimktrains_vslc_sync_edge.sv
// Multi-flop synchronizer for an asynchronous VSLC input, followed by an
// edge-detect flop producing one-clk rise/fall strobes on the synchronized level.
module tt_um_jimktrains_vslc_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic rise,
  output logic fall
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_prev;

  // NOTE: no reset here on purpose; these flops keep tracking the pin through
  // reset so the first strobe after reset reflects a real edge, not a reset artefact.
  always_ff @(posedge clk) begin
    sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
    level_prev <= sync_q[SYNC_STAGES-1];
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~level_prev;
  assign fall = ~sync_q[SYNC_STAGES-1] & level_prev;

endmodule

// File: rtl/tt_um_jimktrains_vslc_capture.sv
// Pulse-width capture: measures high/low phase lengths of capture_in in timer_clk
// ticks, reporting ticks-minus-one so a looped-back VSLC timer reads its periods.
module tt_um_jimktrains_vslc_capture
  import tt_um_jimktrains_vslc_pkg::*;
#(
  parameter int WIDTH       = VSLC_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_clk,
  input  logic             capture_in,
  input  logic             capture_enabled,
  output logic [WIDTH-1:0] high_period,
  output logic [WIDTH-1:0] low_period,
  output logic             high_overflow,
  output logic             low_overflow,
  output logic             capture_valid
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  capture_state_t   state;
  logic             timer_clk_prev;
  logic             tick;
  logic             in_rise;
  logic             in_fall;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] counter_next;
  logic             seen_tick;
  logic             seen_tick_next;
  logic             sat;
  logic             sat_next;
  logic             have_high;

  tt_um_jimktrains_vslc_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk (clk),
    .din (capture_in),
    .rise(in_rise),
    .fall(in_fall)
  );

  always_ff @(posedge clk) begin
    timer_clk_prev <= timer_clk;
  end

  assign tick = timer_clk & ~timer_clk_prev;

  // In-phase counting: the first tick only arms the phase, later ticks count up
  // and stick at COUNT_MAX once one more tick would have wrapped.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    counter_next   = counter;
    seen_tick_next = seen_tick;
    sat_next       = sat;
    if (tick) begin
      if (!seen_tick) begin
        seen_tick_next = 1'b1;
      end else if (counter == COUNT_MAX) begin
        sat_next = 1'b1;
      end else begin
        counter_next = counter + WIDTH'(1);
      end
    end
  end

  // NOTE: reset is synchronous and shares the clear path with capture_enabled=0;
  // all state uses non-blocking assignments so every flop samples the old values.
  always_ff @(posedge clk) begin
    if (!rst_n || !capture_enabled) begin
      state         <= IDLE;
      counter       <= '0;
      seen_tick     <= 1'b0;
      sat           <= 1'b0;
      have_high     <= 1'b0;
      high_period   <= '0;
      low_period    <= '0;
      high_overflow <= 1'b0;
      low_overflow  <= 1'b0;
      capture_valid <= 1'b0;
    end else begin
      capture_valid <= 1'b0;
      unique case (state)
        IDLE: state <= SYNC;

        SYNC: begin
          if (in_rise || in_fall) begin
            state     <= in_rise ? HIGH : LOW;
            counter   <= '0;
            seen_tick <= tick;
            sat       <= 1'b0;
          end
        end

        HIGH: begin
          if (in_fall) begin
            // Edge wins over a coincident tick, which opens the new phase instead.
            high_period   <= counter;
            high_overflow <= sat;
            have_high     <= 1'b1;
            state         <= LOW;
            counter       <= '0;
            seen_tick     <= tick;
            sat           <= 1'b0;
          end else begin
            counter   <= counter_next;
            seen_tick <= seen_tick_next;
            sat       <= sat_next;
          end
        end

        LOW: begin
          if (in_rise) begin
            low_period    <= counter;
            low_overflow  <= sat;
            capture_valid <= have_high;
            state         <= HIGH;
            counter       <= '0;
            seen_tick     <= tick;
            sat           <= 1'b0;
          end else begin
            counter   <= counter_next;
            seen_tick <= seen_tick_next;
            sat       <= sat_next;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_capture.sv
// Directed bench for the VSLC pulse-width capture block; a narrow second
// instance shares all stimulus so counter saturation is reachable quickly.
module tb_tt_um_jimktrains_vslc_capture;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        hov;
    logic        lov;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        timer_clk;
  logic        capture_in;
  logic        capture_enabled;

  logic [15:0] hp16, lp16;
  logic        hov16, lov16, valid16;
  logic [7:0]  hp8, lp8;
  logic        hov8, lov8, valid8;

  int   checks = 0;
  int   errors = 0;
  rec_t q16[$];
  rec_t q8[$];
  event tick_ev;

  tt_um_jimktrains_vslc_capture dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .timer_clk      (timer_clk),
    .capture_in     (capture_in),
    .capture_enabled(capture_enabled),
    .high_period    (hp16),
    .low_period     (lp16),
    .high_overflow  (hov16),
    .low_overflow   (lov16),
    .capture_valid  (valid16)
  );

  tt_um_jimktrains_vslc_capture #(.WIDTH(8)) dut_w8 (
    .clk            (clk),
    .rst_n          (rst_n),
    .timer_clk      (timer_clk),
    .capture_in     (capture_in),
    .capture_enabled(capture_enabled),
    .high_period    (hp8),
    .low_period     (lp8),
    .high_overflow  (hov8),
    .low_overflow   (lov8),
    .capture_valid  (valid8)
  );

  always #5 clk = ~clk;

  // timer_clk = clk/8; tick_ev marks the negedge where it rises.
  initial begin
    timer_clk = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      timer_clk = ~timer_clk;
      if (timer_clk) -> tick_ev;
    end
  end

  always @(negedge clk) begin
    if (valid16) q16.push_back({hp16, lp16, hov16, lov16});
    if (valid8)  q8.push_back({8'h00, hp8, 8'h00, lp8, hov8, lov8});
  end

  function automatic string fmt(input rec_t r);
    return $sformatf("hi=%0d lo=%0d hov=%0b lov=%0b", r.hi, r.lo, r.hov, r.lov);
  endfunction

  // Set the level at the current tick and hold it for the given number of ticks.
  task automatic drive_wave(input logic level, input int ticks);
    capture_in = level;
    repeat (ticks) @(tick_ev);
  endtask

  task automatic restart();
    capture_enabled = 1'b0;
    capture_in      = 1'b0;
    repeat (6) @(negedge clk);
    capture_enabled = 1'b1;
    repeat (2) @(negedge clk);
    q16.delete();
    q8.delete();
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    capture_enabled = 1'b1;
    capture_in      = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({hp16, lp16, hov16, lov16, valid16} !== 35'd0) begin
      errors++;
      $display("FAIL reset_w16: got hi=%0d lo=%0d hov=%0b lov=%0b valid=%0b, expected all 0",
               hp16, lp16, hov16, lov16, valid16);
    end
    checks++;
    if ({hp8, lp8, hov8, lov8, valid8} !== 19'd0) begin
      errors++;
      $display("FAIL reset_w8: got hi=%0d lo=%0d hov=%0b lov=%0b valid=%0b, expected all 0",
               hp8, lp8, hov8, lov8, valid8);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Timer with period_a=5, period_b=2: high 6 ticks, low 3 ticks.
  task automatic test_loopback();
    rec_t exp;
    restart();
    @(tick_ev);
    for (int p = 0; p < 3; p++) begin
      drive_wave(1'b1, 6);
      drive_wave(1'b0, 3);
    end
    drive_wave(1'b1, 1);
    exp = {16'd5, 16'd2, 1'b0, 1'b0};
    checks++;
    if (q16.size() != 3) begin
      errors++;
      $display("FAIL loopback_count: got %0d valids, expected 3", q16.size());
    end
    for (int i = 0; i < 3 && i < q16.size(); i++) begin
      checks++;
      if (q16[i] !== exp) begin
        errors++;
        $display("FAIL loopback_pair%0d: got %s, expected %s", i, fmt(q16[i]), fmt(exp));
      end
    end
    checks++;
    if ({hp16, lp16, valid16} !== {16'd5, 16'd2, 1'b0}) begin
      errors++;
      $display("FAIL loopback_hold: got hi=%0d lo=%0d valid=%0b, expected hi=5 lo=2 valid=0",
               hp16, lp16, valid16);
    end
  endtask

  // Enable mid-high on a 10/4 tick waveform; the partial phase must be dropped.
  task automatic test_enable_mid_phase();
    rec_t exp;
    capture_enabled = 1'b0;
    capture_in      = 1'b0;
    repeat (6) @(negedge clk);
    q16.delete();
    q8.delete();
    @(tick_ev);
    capture_in = 1'b1;
    repeat (3) @(tick_ev);
    capture_enabled = 1'b1;
    repeat (7) @(tick_ev);
    drive_wave(1'b0, 4);
    drive_wave(1'b1, 10);
    drive_wave(1'b0, 4);
    drive_wave(1'b1, 1);
    exp = {16'd9, 16'd3, 1'b0, 1'b0};
    checks++;
    if (q16.size() != 1) begin
      errors++;
      $display("FAIL midphase_count: got %0d valids, expected 1", q16.size());
    end
    if (q16.size() > 0) begin
      checks++;
      if (q16[0] !== exp) begin
        errors++;
        $display("FAIL midphase_pair: got %s, expected %s", fmt(q16[0]), fmt(exp));
      end
    end
  endtask

  // 300-tick high: the 8-bit instance saturates, the 16-bit one does not.
  task automatic test_overflow();
    rec_t exp16[2];
    rec_t exp8[2];
    restart();
    @(tick_ev);
    drive_wave(1'b1, 300);
    drive_wave(1'b0, 3);
    drive_wave(1'b1, 6);
    drive_wave(1'b0, 3);
    drive_wave(1'b1, 1);
    exp16[0] = {16'd299, 16'd2, 1'b0, 1'b0};
    exp16[1] = {16'd5, 16'd2, 1'b0, 1'b0};
    exp8[0]  = {16'h00FF, 16'd2, 1'b1, 1'b0};
    exp8[1]  = {16'd5, 16'd2, 1'b0, 1'b0};
    checks++;
    if (q16.size() != 2 || q8.size() != 2) begin
      errors++;
      $display("FAIL overflow_count: got %0d/%0d valids (w16/w8), expected 2/2",
               q16.size(), q8.size());
    end
    for (int i = 0; i < 2; i++) begin
      if (i < q16.size()) begin
        checks++;
        if (q16[i] !== exp16[i]) begin
          errors++;
          $display("FAIL overflow_w16_pair%0d: got %s, expected %s", i, fmt(q16[i]), fmt(exp16[i]));
        end
      end
      if (i < q8.size()) begin
        checks++;
        if (q8[i] !== exp8[i]) begin
          errors++;
          $display("FAIL overflow_w8_pair%0d: got %s, expected %s", i, fmt(q8[i]), fmt(exp8[i]));
        end
      end
    end
  endtask

  // A 3-clk high pulse between ticks reports high_period=0.
  task automatic test_short_pulse();
    rec_t exp[2];
    restart();
    @(tick_ev);
    drive_wave(1'b1, 4);
    drive_wave(1'b0, 3);
    @(negedge clk);
    capture_in = 1'b1;
    repeat (3) @(negedge clk);
    capture_in = 1'b0;
    @(tick_ev);
    checks++;
    if (hp16 !== 16'd0) begin
      errors++;
      $display("FAIL short_pulse_high: got %0d, expected 0", hp16);
    end
    repeat (2) @(tick_ev);
    drive_wave(1'b1, 1);
    exp[0] = {16'd3, 16'd2, 1'b0, 1'b0};
    exp[1] = {16'd0, 16'd2, 1'b0, 1'b0};
    checks++;
    if (q16.size() != 2) begin
      errors++;
      $display("FAIL short_pulse_count: got %0d valids, expected 2", q16.size());
    end
    for (int i = 0; i < 2 && i < q16.size(); i++) begin
      checks++;
      if (q16[i] !== exp[i]) begin
        errors++;
        $display("FAIL short_pulse_pair%0d: got %s, expected %s", i, fmt(q16[i]), fmt(exp[i]));
      end
    end
  endtask

  // Abort in LOW at count 7 via disable or reset, then require a full fresh pair.
  task automatic test_abort(input bit use_rst);
    rec_t exp;
    restart();
    @(tick_ev);
    drive_wave(1'b1, 3);
    drive_wave(1'b0, 2);
    drive_wave(1'b1, 2);
    capture_in = 1'b0;
    repeat (8) @(tick_ev);
    repeat (2) @(negedge clk);
    checks++;
    if ({hp16, lp16} !== {16'd1, 16'd1}) begin
      errors++;
      $display("FAIL abort%0d_before: got hi=%0d lo=%0d, expected hi=1 lo=1", use_rst, hp16, lp16);
    end
    if (use_rst) rst_n = 1'b0;
    else capture_enabled = 1'b0;
    @(negedge clk);
    checks++;
    if ({hp16, lp16, hov16, lov16, valid16} !== 35'd0) begin
      errors++;
      $display("FAIL abort%0d_clear: got hi=%0d lo=%0d hov=%0b lov=%0b valid=%0b, expected all 0",
               use_rst, hp16, lp16, hov16, lov16, valid16);
    end
    repeat (3) @(negedge clk);
    rst_n           = 1'b1;
    capture_enabled = 1'b1;
    repeat (2) @(negedge clk);
    q16.delete();
    q8.delete();
    @(tick_ev);
    drive_wave(1'b1, 4);
    drive_wave(1'b0, 2);
    drive_wave(1'b1, 1);
    exp = {16'd3, 16'd1, 1'b0, 1'b0};
    checks++;
    if (q16.size() != 1) begin
      errors++;
      $display("FAIL abort%0d_count: got %0d valids, expected 1", use_rst, q16.size());
    end
    if (q16.size() > 0) begin
      checks++;
      if (q16[0] !== exp) begin
        errors++;
        $display("FAIL abort%0d_pair: got %s, expected %s", use_rst, fmt(q16[0]), fmt(exp));
      end
    end
  endtask

  // Fall strobe lands on the same clk as tick 4: high excludes it, low starts with it.
  task automatic test_edge_on_tick();
    rec_t exp;
    restart();
    @(tick_ev);
    capture_in = 1'b1;
    repeat (3) @(tick_ev);
    repeat (6) @(negedge clk);
    capture_in = 1'b0;
    @(tick_ev);
    repeat (2) @(tick_ev);
    drive_wave(1'b1, 1);
    exp = {16'd2, 16'd2, 1'b0, 1'b0};
    checks++;
    if (q16.size() != 1) begin
      errors++;
      $display("FAIL edge_on_tick_count: got %0d valids, expected 1", q16.size());
    end
    if (q16.size() > 0) begin
      checks++;
      if (q16[0] !== exp) begin
        errors++;
        $display("FAIL edge_on_tick_pair: got %s, expected %s", fmt(q16[0]), fmt(exp));
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_enable_mid_phase();
    test_overflow();
    test_short_pulse();
    test_abort(1'b0);
    test_abort(1'b1);
    test_edge_on_tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
